// File: rtl/ecc_pkg.sv
// rtl/ecc_pkg.sv - shared encodings, microword format and FSM states for the ECC point sequencer
package ecc_pkg;

  typedef enum logic [1:0] {
    GF_ADD  = 2'd0,
    GF_SUB  = 2'd1,
    GF_MULT = 2'd2,
    GF_DIV  = 2'd3
  } gf_op_e;

  localparam logic [2:0] R0 = 3'd0;
  localparam logic [2:0] R1 = 3'd1;
  localparam logic [2:0] R2 = 3'd2;
  localparam logic [2:0] R3 = 3'd3;
  localparam logic [2:0] R4 = 3'd4;
  localparam logic [2:0] R5 = 3'd5;
  localparam logic [2:0] R6 = 3'd6;
  localparam logic [2:0] R7 = 3'd7;

  typedef struct packed {
    gf_op_e     op;
    logic [2:0] dst;
    logic [2:0] src_a;
    logic [2:0] src_b;
    logic       last;
  } uword_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FETCH,
    S_ISSUE,
    S_WAIT,
    S_WRITE,
    S_FINISH,
    S_ERROR
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_ZERO_DEN = 2'd1,
    ERR_TIMEOUT  = 2'd2
  } err_e;

  localparam int ADD_LEN = 9;
  localparam int DBL_LEN = 12;

  localparam uword_t UW_HALT = '{op: GF_ADD, dst: R0, src_a: R0, src_b: R0, last: 1'b1};

  function automatic uword_t uw(input gf_op_e op, input logic [2:0] dst,
                                input logic [2:0] src_a, input logic [2:0] src_b,
                                input logic last);
    uword_t w;
    w.op    = op;
    w.dst   = dst;
    w.src_a = src_a;
    w.src_b = src_b;
    w.last  = last;
    return w;
  endfunction

endpackage

// File: rtl/ecc_useq_rom.sv
// rtl/ecc_useq_rom.sv - microprogram ROM, address {op, pc}; op 0 = point add, op 1 = point double
module ecc_useq_rom
  import ecc_pkg::*;
(
  input  logic [4:0] addr,
  output uword_t     word
);

  logic [3:0] idx;
  assign idx = addr[3:0];

  always_comb begin
    word = UW_HALT;
    if (!addr[4]) begin
      case (idx)
        4'd0:    word = uw(GF_SUB,  R5, R3, R1, 1'b0);
        4'd1:    word = uw(GF_SUB,  R6, R2, R0, 1'b0);
        4'd2:    word = uw(GF_DIV,  R7, R5, R6, 1'b0);
        4'd3:    word = uw(GF_MULT, R5, R7, R7, 1'b0);
        4'd4:    word = uw(GF_SUB,  R5, R5, R0, 1'b0);
        4'd5:    word = uw(GF_SUB,  R2, R5, R2, 1'b0);
        4'd6:    word = uw(GF_SUB,  R6, R0, R2, 1'b0);
        4'd7:    word = uw(GF_MULT, R6, R7, R6, 1'b0);
        4'd8:    word = uw(GF_SUB,  R3, R6, R1, 1'b1);
        default: word = UW_HALT;
      endcase
    end else begin
      case (idx)
        4'd0:    word = uw(GF_MULT, R5, R0, R0, 1'b0);
        4'd1:    word = uw(GF_ADD,  R6, R5, R5, 1'b0);
        4'd2:    word = uw(GF_ADD,  R5, R6, R5, 1'b0);
        4'd3:    word = uw(GF_ADD,  R5, R5, R4, 1'b0);
        4'd4:    word = uw(GF_ADD,  R6, R1, R1, 1'b0);
        4'd5:    word = uw(GF_DIV,  R7, R5, R6, 1'b0);
        4'd6:    word = uw(GF_MULT, R5, R7, R7, 1'b0);
        4'd7:    word = uw(GF_SUB,  R5, R5, R0, 1'b0);
        4'd8:    word = uw(GF_SUB,  R2, R5, R0, 1'b0);
        4'd9:    word = uw(GF_SUB,  R6, R0, R2, 1'b0);
        4'd10:   word = uw(GF_MULT, R6, R7, R6, 1'b0);
        4'd11:   word = uw(GF_SUB,  R3, R6, R1, 1'b1);
        default: word = UW_HALT;
      endcase
    end
    // Anything past the end of a program halts rather than running stale words
    if ({28'd0, idx} >= (addr[4] ? 32'(DBL_LEN) : 32'(ADD_LEN))) word = UW_HALT;
  end

endmodule

// File: rtl/ecc_point_seq.sv
// rtl/ecc_point_seq.sv - EC point add/double microsequencer driving a GF(p) arithmetic unit
// Optional GFAU_TIMEOUT_EN bounds each WAIT to TIMEOUT cycles (error code 2).
module ecc_point_seq
  import ecc_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 2047
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_op,
  input  logic [WIDTH-1:0] i_x1,
  input  logic [WIDTH-1:0] i_y1,
  input  logic [WIDTH-1:0] i_x2,
  input  logic [WIDTH-1:0] i_y2,
  input  logic [WIDTH-1:0] i_a,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err,
  output logic [1:0]       o_err_code,
  output logic [WIDTH-1:0] o_x3,
  output logic [WIDTH-1:0] o_y3,
  output logic [WIDTH-1:0] o_in_0,
  output logic [WIDTH-1:0] o_in_1,
  output logic [1:0]       o_operation_select,
  output logic             o_done_from_control,
  input  logic [WIDTH-1:0] i_result,
  input  logic             i_done_to_control
);

  state_e           state, state_nxt;
  logic             op_q;
  logic [3:0]       pc;
  logic [WIDTH-1:0] rf [8];
  logic [WIDTH-1:0] res_q;
  err_e             err_code_q;
  uword_t           word;
  logic             div_zero;
  logic             timeout_hit;

  ecc_useq_rom u_rom (
    .addr ({op_q, pc}),
    .word (word)
  );

  assign div_zero = (word.op == GF_DIV) && (rf[word.src_b] == '0);

`ifdef GFAU_TIMEOUT_EN
  localparam logic [10:0] WAIT_LAST = 11'(TIMEOUT - 1);
  logic [10:0] wait_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wait_cnt <= '0;
    end else if (state == S_ISSUE) begin
      wait_cnt <= '0;
    end else if (state == S_WAIT) begin
      wait_cnt <= wait_cnt + 11'd1;
    end
  end

  assign timeout_hit = (wait_cnt == WAIT_LAST);
`else
  localparam int UNUSED_TIMEOUT = TIMEOUT;
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (i_start) state_nxt = S_LOAD;
      S_LOAD:   state_nxt = S_FETCH;
      S_FETCH:  state_nxt = div_zero ? S_ERROR : S_ISSUE;
      S_ISSUE:  state_nxt = S_WAIT;
      S_WAIT: begin
        if (i_done_to_control) state_nxt = S_WRITE;
        else if (timeout_hit)  state_nxt = S_ERROR;
      end
      S_WRITE:  state_nxt = word.last ? S_FINISH : S_FETCH;
      S_FINISH: state_nxt = S_IDLE;
      S_ERROR:  state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      op_q                <= 1'b0;
      pc                  <= '0;
      res_q               <= '0;
      err_code_q          <= ERR_NONE;
      for (int i = 0; i < 8; i++) rf[i] <= '0;
      o_busy              <= 1'b0;
      o_done              <= 1'b0;
      o_err               <= 1'b0;
      o_err_code          <= 2'd0;
      o_x3                <= '0;
      o_y3                <= '0;
      o_in_0              <= '0;
      o_in_1              <= '0;
      o_operation_select  <= 2'd0;
      o_done_from_control <= 1'b0;
    end else begin
      // Go, busy and done are registered from the FSM so they are glitch-free
      o_busy              <= (state_nxt != S_IDLE);
      o_done_from_control <= (state_nxt == S_ISSUE);
      o_done              <= (state == S_FINISH) || (state == S_ERROR);
      case (state)
        S_IDLE: if (i_start) op_q <= i_op;
        S_LOAD: begin
          rf[0]      <= i_x1;
          rf[1]      <= i_y1;
          rf[2]      <= i_x2;
          rf[3]      <= i_y2;
          rf[4]      <= i_a;
          pc         <= '0;
          o_err      <= 1'b0;
          o_err_code <= 2'd0;
          err_code_q <= ERR_NONE;
        end
        S_FETCH: begin
          o_in_0             <= rf[word.src_a];
          o_in_1             <= rf[word.src_b];
          o_operation_select <= word.op;
          if (div_zero) err_code_q <= ERR_ZERO_DEN;
        end
        S_WAIT: begin
          if (i_done_to_control) res_q <= i_result;
          else if (timeout_hit)  err_code_q <= ERR_TIMEOUT;
        end
        S_WRITE: begin
          rf[word.dst] <= res_q;
          if (!word.last) pc <= pc + 4'd1;
        end
        S_FINISH: begin
          o_x3 <= rf[2];
          o_y3 <= rf[3];
        end
        S_ERROR: begin
          o_err      <= 1'b1;
          o_err_code <= err_code_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ecc_point_seq.sv
// tb/tb_ecc_point_seq.sv - scoreboard bench with a mod-17 responder of programmable latency
module tb_ecc_point_seq;

  localparam int WIDTH   = 32;
  localparam int TIMEOUT = 2047;
  localparam int P       = 17;
  localparam int CURVE_A = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             op = 1'b0;
  logic [WIDTH-1:0] x1 = '0, y1 = '0, x2 = '0, y2 = '0, a = '0;
  logic             busy, done, err;
  logic [1:0]       err_code;
  logic [WIDTH-1:0] x3, y3, in_0, in_1;
  logic [1:0]       sel;
  logic             go;
  logic [WIDTH-1:0] result = '0;
  logic             done_to = 1'b0;

  ecc_point_seq #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .i_clk               (clk),
    .i_rst_n             (rst_n),
    .i_start             (start),
    .i_op                (op),
    .i_x1                (x1),
    .i_y1                (y1),
    .i_x2                (x2),
    .i_y2                (y2),
    .i_a                 (a),
    .o_busy              (busy),
    .o_done              (done),
    .o_err               (err),
    .o_err_code          (err_code),
    .o_x3                (x3),
    .o_y3                (y3),
    .o_in_0              (in_0),
    .o_in_1              (in_1),
    .o_operation_select  (sel),
    .o_done_from_control (go),
    .i_result            (result),
    .i_done_to_control   (done_to)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  typedef struct {
    int    x3;
    int    y3;
    int    err;
    int    code;
    int    done_cyc;
    string tag;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check({mon_e.tag, "_err"}, err, mon_e.err);
        check({mon_e.tag, "_code"}, err_code, mon_e.code);
        if (mon_e.err == 0) begin
          check({mon_e.tag, "_x3"}, x3, mon_e.x3);
          check({mon_e.tag, "_y3"}, y3, mon_e.y3);
        end
        check({mon_e.tag, "_done_cycle"}, cyc, mon_e.done_cyc);
      end
    end
  end

  // Responder: plain mod-p arithmetic unit
  int lat = 1;
  bit never = 1'b0;
  int go_cnt = 0, div_cnt = 0, unstable = 0;
  int ra, rb, rs, rr;

  function automatic int inv_p(input int b);
    for (int i = 1; i < P; i++) if ((b * i) % P == 1) return i;
    return 0;
  endfunction

  function automatic int gf(input int x, input int y, input int s);
    case (s)
      0:       return (x + y) % P;
      1:       return (x + P - y) % P;
      2:       return (x * y) % P;
      default: return (x * inv_p(y)) % P;
    endcase
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && go) begin
        ra = int'(in_0);
        rb = int'(in_1);
        rs = int'(sel);
        go_cnt++;
        if (rs == 3) div_cnt++;
        rr = gf(ra, rb, rs);
        if (!never) begin
          @(posedge clk);
          for (int k = 1; k <= lat; k++) begin
            if (k == lat) begin
              #1;
              done_to = 1'b1;
              result  = WIDTH'(rr);
            end
            @(negedge clk);
            if (rst_n && (int'(in_0) != ra || int'(in_1) != rb || int'(sel) != rs)) unstable++;
            @(posedge clk);
          end
          #1 done_to = 1'b0;
        end
      end
    end
  end

  task automatic issue(input bit o, input int px1, input int py1, input int px2, input int py2,
                       input int ex, input int ey, input int eerr, input int ecode,
                       input int off, input bit push, input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    start = 1'b1;
    op    = o;
    x1    = WIDTH'(px1);
    y1    = WIDTH'(py1);
    x2    = WIDTH'(px2);
    y2    = WIDTH'(py2);
    a     = WIDTH'(CURVE_A);
    @(posedge clk);
    #1;
    start = 1'b0;
    if (push) begin
      e.x3 = ex; e.y3 = ey; e.err = eerr; e.code = ecode;
      e.done_cyc = cyc + off;
      e.tag = tag;
      sb.push_back(e);
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((sb.size() != 0 || busy) && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (n >= budget) check("drain_timeout", 0, 1);
    repeat (3) @(posedge clk);
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_busy"}, busy, 0);
    check({pfx, "_done"}, done, 0);
    check({pfx, "_err"}, err, 0);
    check({pfx, "_code"}, err_code, 0);
    check({pfx, "_x3"}, x3, 0);
    check({pfx, "_y3"}, y3, 0);
    check({pfx, "_in0"}, in_0, 0);
    check({pfx, "_in1"}, in_1, 0);
    check({pfx, "_sel"}, sel, 0);
    check({pfx, "_go"}, go, 0);
  endtask

  task automatic clear_counts();
    go_cnt = 0;
    div_cnt = 0;
    unstable = 0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;

    // Add (5,1)+(6,3) -> (10,6), L=1
    lat = 1;
    clear_counts();
    issue(1'b0, 5, 1, 6, 3, 10, 6, 0, 0, 2 + 9 * 4, 1'b1, "add_l1");
    drain(500);
    check("add_l1_go_pulses", go_cnt, 9);
    check("add_l1_div_issued", div_cnt, 1);

    // Double (5,1) -> (6,3), L=40, with an ignored start while busy
    lat = 40;
    clear_counts();
    issue(1'b1, 5, 1, 0, 0, 6, 3, 0, 0, 2 + 12 * 43, 1'b1, "dbl_l40");
    repeat (100) @(posedge clk);
    #1;
    start = 1'b1; op = 1'b0; x1 = 9; y1 = 9; x2 = 9; y2 = 9;
    @(posedge clk);
    #1 start = 1'b0;
    drain(2000);
    check("dbl_go_pulses", go_cnt, 12);
    check("dbl_operands_stable", unstable, 0);
    check("dbl_busy_after", busy, 0);

    // Zero denominator: (5,1)+(5,16) faults at pc=2
    lat = 1;
    clear_counts();
    issue(1'b0, 5, 1, 5, 16, 0, 0, 1, 1, 3 + 2 * 4, 1'b1, "zero_den");
    drain(500);
    check("zero_den_go_pulses", go_cnt, 2);
    check("zero_den_no_div", div_cnt, 0);
    check("zero_den_err_held", err, 1);
    check("zero_den_x3_held", x3, 6);

`ifdef GFAU_TIMEOUT_EN
    never = 1'b1;
    clear_counts();
    issue(1'b0, 5, 1, 6, 3, 0, 0, 1, 2, 4 + TIMEOUT, 1'b1, "timeout");
    drain(TIMEOUT + 500);
    never = 1'b0;
    @(posedge clk);
    #1 done_to = 1'b1;
    @(posedge clk);
    #1 done_to = 1'b0;
    repeat (5) @(posedge clk);
    check("timeout_go_pulses", go_cnt, 1);
    check("timeout_late_done_busy", busy, 0);
    check("timeout_code_held", err_code, 2);
`endif

    // Reset mid-WAIT of the first micro-op
    lat = 40;
    clear_counts();
    issue(1'b0, 5, 1, 6, 3, 0, 0, 0, 0, 0, 1'b0, "aborted");
    repeat (10) @(posedge clk);
    check("abort_in_wait_busy", busy, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    repeat (60) @(posedge clk);
    #1 rst_n = 1'b1;

    lat = 2;
    clear_counts();
    issue(1'b0, 5, 1, 6, 3, 10, 6, 0, 0, 2 + 9 * 5, 1'b1, "after_reset");
    drain(500);
    check("after_reset_go_pulses", go_cnt, 9);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_total);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ecc_point_seq.md
# ecc_point_seq

Initiator-side sequencer for the GF(p) arithmetic unit. It accepts an elliptic-curve point add or point double request, loads the coordinates into an internal 8×WIDTH register file, and runs a fixed microprogram. Each micro-op is issued to the arithmetic unit over its operand / operation_select / done_from_control request port, and the sequencer waits for done_to_control before writing back. It sits between the ECC scalar-multiply controller and the GF arithmetic unit. Prime is wired to the arithmetic unit directly.

## Interface
- WIDTH, 32: field element width
- TIMEOUT, 2047: maximum WAIT cycles per micro-op (used only with GFAU_TIMEOUT_EN)

Clock and reset:
- i_clk  in  1  clock
- i_rst_n  in  1  reset, asynchronous, active-low

Host side:
- i_start  in  1  request strobe, sampled in IDLE only
- i_op  in  1  0 = add (P+Q), 1 = double (2P)
- i_x1, i_y1, i_x2, i_y2, i_a  in  WIDTH  coordinates and curve a; x2/y2 ignored for double
- o_busy  out  1  high from LOAD through FINISH/ERROR
- o_done  out  1  one-cycle completion pulse, also on error
- o_err  out  1  error flag, held until next accepted start
- o_err_code  out  2  0 none, 1 zero denominator, 2 timeout
- o_x3, o_y3  out  WIDTH  result, valid with o_done when o_err=0, held until next start

Arithmetic-unit side:
- o_in_0, o_in_1  out  WIDTH  operands; for DIV, in_0 = numerator, in_1 = denominator
- o_operation_select  out  2  0 ADD, 1 SUB, 2 MULT, 3 DIV
- o_done_from_control  out  1  go strobe
- i_result  in  WIDTH  result
- i_done_to_control  in  1  result-valid strobe

## Operation
Register map:
- r0 x1, r1 y1, r2 x2, then x3
- r3 y2, then y3
- r4 a
- r5–r7 temporaries; r7 holds lambda

Micro-op format is dst = srcA op srcB.

Add, 9 micro-ops:
- r5=r3−r1; r6=r2−r0; r7=r5/r6; r5=r7·r7
- r5=r5−r0; r2=r5−r2; r6=r0−r2; r6=r7·r6; r3=r6−r1 (last)

Double, 12 micro-ops:
- r5=r0·r0; r6=r5+r5; r5=r6+r5; r5=r5+r4; r6=r1+r1; r7=r5/r6
- r5=r7·r7; r5=r5−r0; r2=r5−r0; r6=r0−r2; r6=r7·r6; r3=r6−r1 (last)

Result values are taken as-is from the arithmetic unit. Representation (e.g. Montgomery form) is the caller's responsibility.

States and transitions:
- IDLE: on i_start, latch i_op and go to LOAD.
- LOAD: write r0–r4 from inputs; clear pc, o_err and o_err_code.
- FETCH: register o_in_0, o_in_1 and o_operation_select from the ROM word and register file. If the op is DIV and regfile[srcB]==0, go to ERROR with code 1; no go is issued.
- ISSUE: o_done_from_control=1 for exactly this cycle.
- WAIT: hold operands and select stable. On i_done_to_control, capture i_result and go to WRITE.
- WRITE: regfile[dst] ← captured result. If the word is last, go to FINISH; otherwise increment pc and go to FETCH.
- FINISH: o_x3←r2, o_y3←r3, o_done=1, then IDLE.
- ERROR: o_err=1, o_done=1, then IDLE.

Boundary rules:
- i_start outside IDLE is ignored.
- i_done_to_control outside WAIT is ignored; only the first strobe in WAIT is taken.
- Reset asserted mid-operation returns to IDLE immediately. o_done_from_control drops asynchronously, and the arithmetic unit shares the same reset.

## Timing
- Reset values: every output is 0; register file and pc are 0.
- Responder latency L (≥1) is the number of cycles from the go cycle to the cycle in which done is high.
- Each micro-op takes L+3 cycles (FETCH, ISSUE, L WAIT cycles, WRITE).
- o_done is asserted 2 + N·(L+3) cycles after the start sample, with N = 9 for add and 12 for double.
- A zero-denominator error asserts o_done 2 cycles after entering the faulting FETCH.
- Operand outputs change only in FETCH.

## Configuration
GFAU_TIMEOUT_EN:
- Defined: an 11-bit WAIT counter is compiled in, cleared in ISSUE. Reaching TIMEOUT without done goes to ERROR with code 2, and any late done is ignored.
- Undefined: the counter is absent, WAIT is unbounded and code 2 is never produced.

## Structure
- Package ecc_pkg holds:
  - GF op encodings
  - register indices
  - packed microword typedef {op[1:0], dst[2:0], srcA[2:0], srcB[2:0], last}
  - state enum
  - error codes
  - add/double program lengths
- Sub-module ecc_useq_rom is a combinational ROM indexed by {op, pc[3:0]} and returns a microword.

## Test plan
Bench uses a plain mod-p responder model with programmable latency; p=17, a=2.
- Add (5,1)+(6,3), L=1 → o_x3=10, o_y3=6, o_err=0; exactly 9 go pulses; o_done at start+38.
- Double (5,1), L=40 → (6,3); 12 go pulses; operands stable throughout every WAIT.
- Add (5,1)+(5,16) → o_err=1, code 1 at pc=2; only 2 go pulses, no DIV issued.
- With GFAU_TIMEOUT_EN, responder never answers → code 2 after TIMEOUT WAIT cycles; a late done is ignored.
- i_start pulsed while busy → ignored; first result unchanged.
- Reset deasserted-then-asserted mid-WAIT → all outputs 0 immediately; next start completes normally.
